tristate_bus_reader: RTL and testbench

Receive-side endpoint of the shared tristate data bus. It observes the resolved bus value and the remote driver's enable strobe, qualifies each drive window with a settle/turnaround state machine, and captures one word per window into a small first-word-fall-through FIFO. A valid/ready interface passes the buffered words to local logic. When the FIFO fills, the block raises a backpressure hold to the bus driver and flags any word that is lost.

---
 rtl/tristate_bus_reader_pkg.sv | 21 ++
 rtl/tristate_bus_reader_fifo.sv | 80 ++++++++
 rtl/tristate_bus_reader.sv | 135 +++++++++++++
 tb/tb_tristate_bus_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_reader_pkg
// Description : Constants shared by the tristate bus endpoints: the bus-wide
//               word width (common with the tristate driver) and the state
//               encoding of the reader's window-qualification FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package tristate_bus_reader_pkg;

    // Bus-wide word width, common to driver and reader.
    localparam int DATA_WIDTH = 8;

    // Window-qualification FSM encoding.
    localparam int         STATE_W       = 2;
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SETTLE     = 2'd1;
    localparam logic [1:0] ST_TURNAROUND = 2'd2;

endpackage : tristate_bus_reader_pkg
`default_nettype wire

// File: rtl/tristate_bus_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented combinationally from storage, so it is visible as
//               soon as the FIFO is non-empty.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               push, push_data- write request and word
//               pop            - advance head (ignored when empty)
//               head           - current head word
//               empty, full    - occupancy flags
//               level          - entry count, 0..FIFO_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic w_do_pop;
    logic w_do_push;

    // A push into a full FIFO is legal only when the head leaves at the same
    // edge; the freed slot is the one the write pointer already points at.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_level == '0);
    assign full  = (r_level == LVL_FULL);
    assign level = r_level;

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/tristate_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_reader
// Description : Receive endpoint of the shared tristate bus. Qualifies each
//               remote drive window (IDLE -> SETTLE -> TURNAROUND), captures
//               one word per window into a FWFT FIFO, and exposes the words
//               over valid/ready. Raises a hold to the driver as the FIFO
//               nears full and flags dropped words with a sticky overrun.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               bus_data, bus_drive - resolved bus value and remote enable
//               bus_hold            - registered backpressure to the driver
//               rd_data, rd_valid,
//               rd_ready            - FIFO head consumer interface
//               overrun, ovr_clr    - sticky drop flag and its clear
//               fill_level          - FIFO entry count
// Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_reader #(
    parameter int DATA_WIDTH = tristate_bus_reader_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         bus_data,
    input  logic                          bus_drive,
    output logic                          bus_hold,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    import tristate_bus_reader_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Hold threshold leaves one free slot for a window already in SETTLE.
    localparam logic [LVL_W-1:0] HOLD_LEVEL = LVL_W'(FIFO_DEPTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               w_capture;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [LVL_W-1:0]   w_level;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    logic               r_overrun;
    logic               r_hold;

    // ------------------------------------------------------------------
    // Window-qualification FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (bus_drive)  w_state_next = ST_SETTLE;
            // A drive that lasts only one sample is a glitch and aborts.
            ST_SETTLE:     w_state_next = bus_drive ? ST_TURNAROUND : ST_IDLE;
            ST_TURNAROUND: if (!bus_drive) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    // Exactly one capture per window: the second sampled-high edge.
    always_comb begin
        w_capture = 1'b0;
        if (r_state == ST_SETTLE) begin
            w_capture = bus_drive;
        end
    end

    // ------------------------------------------------------------------
    // FIFO and flow control
    // ------------------------------------------------------------------
    assign w_pop  = ~w_fifo_empty & rd_ready;
    assign w_push = w_capture & (~w_fifo_full | w_pop);
    assign w_drop = w_capture & w_fifo_full & ~w_pop;

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (bus_data),
        .pop       (w_pop),
        .head      (rd_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (w_level)
    );

    // Set beats clear so a drop coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Hold follows the registered count one edge later, keeping the
    // driver-facing signal free of any path from the bus inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 1'b0;
        end else begin
            r_hold <= (w_level >= HOLD_LEVEL);
        end
    end

    assign rd_valid   = ~w_fifo_empty;
    assign fill_level = w_level;
    assign overrun    = r_overrun;
    assign bus_hold   = r_hold;

endmodule : tristate_bus_reader
`default_nettype wire

// File: tb/tb_tristate_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tristate_bus_reader
// Description : Self-checking bench for tristate_bus_reader. Expected words
//               are queued when a capturing window is driven and compared
//               against the FIFO head as it is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_data;
    logic       bus_drive;
    logic       bus_hold;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       overrun;
    logic       ovr_clr;
    logic [2:0] fill_level;

    int total  = 0;
    int passed = 0;
    logic [7:0] exp_q [$];

    tristate_bus_reader #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_data   (bus_data),
        .bus_drive  (bus_drive),
        .bus_hold   (bus_hold),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two sampled-high edges then one low edge: one captured word.
    task automatic window(input logic [7:0] d);
        bus_data  = d;
        bus_drive = 1'b1;
        step();
        step();
        bus_drive = 1'b0;
        bus_data  = 'z;
        step();
    endtask

    task automatic fill4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            window(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic drain(input string tag);
        int n;
        logic [7:0] e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== e)
                $display("FAIL %s_pop%0d: got valid=%b data=%h, want valid=1 data=%h",
                         tag, i, rd_valid, rd_data, e);
            else passed++;
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        total++;
        if (fill_level !== 3'd0 || rd_valid !== 1'b0)
            $display("FAIL %s_empty: got level=%0d valid=%b, want level=0 valid=0",
                     tag, fill_level, rd_valid);
        else passed++;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_data = 'z; bus_drive = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || bus_hold !== 1'b0 ||
            overrun !== 1'b0 || fill_level !== 3'd0)
            $display("FAIL reset_values: got valid=%b data=%h hold=%b ovr=%b level=%0d, want 0 00 0 0 0",
                     rd_valid, rd_data, bus_hold, overrun, fill_level);
        else passed++;
    endtask

    task automatic test_single_window();
        bus_data = 8'hA5; bus_drive = 1'b1;
        step();
        total++;
        if (rd_valid !== 1'b0) $display("FAIL single_first_edge: got valid=%b want 0", rd_valid);
        else passed++;
        step();
        exp_q.push_back(8'hA5);
        total++;
        if (rd_valid !== 1'b1 || fill_level !== 3'd1)
            $display("FAIL single_capture: got valid=%b level=%0d, want valid=1 level=1", rd_valid, fill_level);
        else passed++;
        step();
        bus_drive = 1'b0; bus_data = 'z;
        step();
        total++;
        if (fill_level !== 3'd1) $display("FAIL single_one_word: got level=%0d want 1", fill_level);
        else passed++;
        drain("single");
    endtask

    task automatic test_glitch();
        bus_data = 8'h3C; bus_drive = 1'b1;
        step();
        bus_drive = 1'b0; bus_data = 'z;
        step();
        total++;
        if (fill_level !== 3'd0 || rd_valid !== 1'b0)
            $display("FAIL glitch_no_capture: got level=%0d valid=%b, want 0 0", fill_level, rd_valid);
        else passed++;
        // Back in IDLE: the next window must again need two high edges.
        bus_data = 8'h5A; bus_drive = 1'b1;
        step();
        total++;
        if (rd_valid !== 1'b0) $display("FAIL glitch_idle_return: got valid=%b want 0", rd_valid);
        else passed++;
        step();
        exp_q.push_back(8'h5A);
        bus_drive = 1'b0; bus_data = 'z;
        step();
        drain("glitch");
    endtask

    task automatic test_fill_overrun();
        for (int k = 1; k <= 4; k++) begin
            bus_data = 8'(k); bus_drive = 1'b1;
            step();
            step();
            exp_q.push_back(8'(k));
            total++;
            if (fill_level !== 3'(k) || bus_hold !== (k - 1 >= 3))
                $display("FAIL fill_capture%0d: got level=%0d hold=%b, want level=%0d hold=%b",
                         k, fill_level, bus_hold, k, (k - 1 >= 3));
            else passed++;
            bus_drive = 1'b0; bus_data = 'z;
            step();
            total++;
            if (bus_hold !== (k >= 3))
                $display("FAIL fill_hold%0d: got %b want %b", k, bus_hold, (k >= 3));
            else passed++;
        end
        bus_data = 8'h05; bus_drive = 1'b1;
        step();
        step();
        total++;
        if (overrun !== 1'b1 || fill_level !== 3'd4)
            $display("FAIL fill_drop: got ovr=%b level=%0d, want ovr=1 level=4", overrun, fill_level);
        else passed++;
        bus_drive = 1'b0; bus_data = 'z;
        step();
        drain("fill");
        total++;
        if (bus_hold !== 1'b0) $display("FAIL fill_hold_release: got %b want 0", bus_hold);
        else passed++;
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [7:0] e;
        fill4(8'h01);
        bus_data = 8'h05; bus_drive = 1'b1;
        step();
        e = exp_q.pop_front();
        total++;
        if (rd_data !== e) $display("FAIL fullpop_head: got %h want %h", rd_data, e);
        else passed++;
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        exp_q.push_back(8'h05);
        total++;
        if (overrun !== 1'b0 || fill_level !== 3'd4)
            $display("FAIL fullpop_accept: got ovr=%b level=%0d, want ovr=0 level=4", overrun, fill_level);
        else passed++;
        bus_drive = 1'b0; bus_data = 'z;
        step();
        drain("fullpop");
    endtask

    task automatic test_ovr_race();
        fill4(8'h11);
        bus_data = 8'h15; bus_drive = 1'b1;
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        total++;
        if (overrun !== 1'b1) $display("FAIL race_set_wins: got %b want 1", overrun);
        else passed++;
        bus_drive = 1'b0; bus_data = 'z;
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) $display("FAIL race_lone_clear: got %b want 0", overrun);
        else passed++;
        drain("race");
    endtask

    task automatic test_reset_mid();
        window(8'h66);
        total++;
        if (fill_level !== 3'd1) $display("FAIL rstmid_prefill: got level=%0d want 1", fill_level);
        else passed++;
        bus_data = 8'h77; bus_drive = 1'b1;
        step();
        rst = 1'b1;
        #1;
        exp_q.delete();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || bus_hold !== 1'b0 ||
            overrun !== 1'b0 || fill_level !== 3'd0)
            $display("FAIL rstmid_values: got valid=%b data=%h hold=%b ovr=%b level=%0d, want 0 00 0 0 0",
                     rd_valid, rd_data, bus_hold, overrun, fill_level);
        else passed++;
        step();
        rst = 1'b0;
        step();
        total++;
        if (rd_valid !== 1'b0) $display("FAIL rstmid_first_edge: got valid=%b want 0", rd_valid);
        else passed++;
        step();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h77)
            $display("FAIL rstmid_capture: got valid=%b data=%h, want valid=1 data=77", rd_valid, rd_data);
        else passed++;
        exp_q.push_back(8'h77);
        bus_drive = 1'b0; bus_data = 'z;
        step();
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_glitch();
        test_fill_overrun();
        test_full_pop();
        test_ovr_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_tristate_bus_reader
`default_nettype wire
